// File: rtl/horner_datapath.sv
// rtl/horner_datapath.sv - Fixed-point Horner step datapath (acc = acc*x + c) with saturation
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   dp_reset_i            synchronous per-evaluation clear
//   rd_signal_i/signal_i  sample capture (data valid with the strobe)
//   rd_coeff_i/coeff_i    coefficient capture (data valid the cycle after the strobe)
//   mul_valid_i           start acc*x, mul_done_o pulses MUL_LAT cycles later
//   add_valid_i           start prod+coeff, add_done_o pulses one cycle later
//   load_result_i         register acc into result_o, result_valid_o pulses next cycle
//   overflow_o            a saturation happened in the evaluation shown on result_o
module horner_datapath #(
    parameter int DATA_W  = 16,
    parameter int FRAC_W  = 12,
    parameter int MUL_LAT = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              dp_reset_i,
    input  logic              rd_signal_i,
    input  logic [DATA_W-1:0] signal_i,
    input  logic              rd_coeff_i,
    input  logic [DATA_W-1:0] coeff_i,
    input  logic              mul_valid_i,
    input  logic              add_valid_i,
    input  logic              load_result_i,
    output logic              mul_done_o,
    output logic              add_done_o,
    output logic [DATA_W-1:0] result_o,
    output logic              result_valid_o,
    output logic              overflow_o
);

    localparam int PW = 2 * DATA_W;

    localparam logic signed [PW:0] HALF  = (PW+1)'(1) << (FRAC_W - 1);
    localparam logic signed [PW:0] MAX_W = {{(PW+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PW:0] MIN_W = {{(PW+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0]  MAX_D = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0]  MIN_D = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W-1:0] x_q, coeff_q, prod_q, acc_q;
    logic signed [DATA_W-1:0] op_a_q, op_x_q;
    logic [DATA_W-1:0]        result_q;
    logic [MUL_LAT-1:0]       mul_vld_q;
    logic                     sat_sticky, add_pend, rd_coeff_d, ovf_q, result_valid_q;

    logic                     mul_accept, mul_finish, mul_ovf, add_ovf;
    logic [MUL_LAT:0]         vld_chain;
    logic signed [DATA_W-1:0] mul_a, mul_b;
    logic signed [PW-1:0]     raw;
    logic signed [PW:0]       rounded, shifted;
    logic [DATA_W-1:0]        mul_res, add_res;
    logic [DATA_W:0]          sum;

    always_comb begin
        // A new multiply is refused while one is in flight, including its done cycle.
        mul_accept = mul_valid_i & ~(|mul_vld_q);
        // Prepending the accept bit lets MUL_LAT = 1 finish in the accept cycle
        // without a special case; stage MUL_LAT-1 of the chain is "result due next edge".
        vld_chain  = {mul_vld_q, mul_accept};
        mul_finish = vld_chain[MUL_LAT-1];

        // Operands are frozen at accept; with MUL_LAT = 1 they are used directly.
        mul_a   = mul_accept ? acc_q : op_a_q;
        mul_b   = mul_accept ? x_q   : op_x_q;
        raw     = mul_a * mul_b;
        rounded = {raw[PW-1], raw} + HALF;
        shifted = rounded >>> FRAC_W;
        mul_ovf = (shifted > MAX_W) || (shifted < MIN_W);
        if (mul_ovf) begin
            mul_res = shifted[PW] ? MIN_D : MAX_D;
        end else begin
            mul_res = shifted[DATA_W-1:0];
        end

        sum     = {prod_q[DATA_W-1], prod_q} + {coeff_q[DATA_W-1], coeff_q};
        add_ovf = sum[DATA_W] ^ sum[DATA_W-1];
        if (add_ovf) begin
            add_res = sum[DATA_W] ? MIN_D : MAX_D;
        end else begin
            add_res = sum[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_q            <= '0;
            coeff_q        <= '0;
            prod_q         <= '0;
            acc_q          <= '0;
            op_a_q         <= '0;
            op_x_q         <= '0;
            mul_vld_q      <= '0;
            sat_sticky     <= 1'b0;
            add_pend       <= 1'b0;
            rd_coeff_d     <= 1'b0;
            result_q       <= '0;
            ovf_q          <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            // The result register sees the pre-clear accumulator even when
            // dp_reset_i arrives in the same cycle.
            result_valid_q <= load_result_i;
            if (load_result_i) begin
                result_q <= acc_q;
                ovf_q    <= sat_sticky;
            end

            if (dp_reset_i) begin
                x_q        <= '0;
                coeff_q    <= '0;
                prod_q     <= '0;
                acc_q      <= '0;
                op_a_q     <= '0;
                op_x_q     <= '0;
                mul_vld_q  <= '0;
                sat_sticky <= 1'b0;
                add_pend   <= 1'b0;
                rd_coeff_d <= 1'b0;
            end else begin
                rd_coeff_d <= rd_coeff_i;
                if (rd_signal_i) begin
                    x_q <= signal_i;
                end
                if (rd_coeff_d) begin
                    coeff_q <= coeff_i;
                end
                mul_vld_q <= vld_chain[MUL_LAT-1:0];
                if (mul_accept) begin
                    op_a_q <= acc_q;
                    op_x_q <= x_q;
                end
                if (mul_finish) begin
                    prod_q <= mul_res;
                end
                add_pend <= add_valid_i;
                if (add_valid_i) begin
                    acc_q <= add_res;
                end
                if ((mul_finish && mul_ovf) || (add_valid_i && add_ovf)) begin
                    sat_sticky <= 1'b1;
                end
            end
        end
    end

    assign mul_done_o     = mul_vld_q[MUL_LAT-1];
    assign add_done_o     = add_pend;
    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;
    assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_horner_datapath.sv
// tb/tb_horner_datapath.sv - Scoreboard testbench for horner_datapath
module tb_horner_datapath;

    localparam int DATA_W  = 16;
    localparam int FRAC_W  = 12;
    localparam int MUL_LAT = 3;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              dp_reset_i, rd_signal_i, rd_coeff_i, mul_valid_i, add_valid_i, load_result_i;
    logic [DATA_W-1:0] signal_i, coeff_i;
    logic              mul_done_o, add_done_o, result_valid_o, overflow_o;
    logic [DATA_W-1:0] result_o;

    horner_datapath #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .MUL_LAT(MUL_LAT)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .dp_reset_i    (dp_reset_i),
        .rd_signal_i   (rd_signal_i),
        .signal_i      (signal_i),
        .rd_coeff_i    (rd_coeff_i),
        .coeff_i       (coeff_i),
        .mul_valid_i   (mul_valid_i),
        .add_valid_i   (add_valid_i),
        .load_result_i (load_result_i),
        .mul_done_o    (mul_done_o),
        .add_done_o    (add_done_o),
        .result_o      (result_o),
        .result_valid_o(result_valid_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] val;
        logic        ovf;
    } exp_t;

    exp_t mul_q[$];
    exp_t add_q[$];
    exp_t res_q[$];
    exp_t me;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        $display("FAIL %s: actual pulse required none (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a done/valid pulse.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (mul_done_o) begin
                if (mul_q.size() == 0) unexpected("mul_done");
                else begin
                    me = mul_q.pop_front();
                    chk("mul_done_cycle", cyc, me.cyc);
                    chk("prod", {16'h0, $unsigned(dut.prod_q)}, {16'h0, me.val});
                end
            end
            if (add_done_o) begin
                if (add_q.size() == 0) unexpected("add_done");
                else begin
                    me = add_q.pop_front();
                    chk("add_done_cycle", cyc, me.cyc);
                    chk("acc", {16'h0, $unsigned(dut.acc_q)}, {16'h0, me.val});
                end
            end
            if (result_valid_o) begin
                if (res_q.size() == 0) unexpected("result_valid");
                else begin
                    me = res_q.pop_front();
                    chk("result_cycle", cyc, me.cyc);
                    chk("result", {16'h0, result_o}, {16'h0, me.val});
                    chk("overflow", {31'h0, overflow_o}, {31'h0, me.ovf});
                end
            end
        end
    end

    task automatic adv();
        @(posedge clk_i);
        #1;
        rd_signal_i   = 1'b0;
        rd_coeff_i    = 1'b0;
        mul_valid_i   = 1'b0;
        add_valid_i   = 1'b0;
        load_result_i = 1'b0;
        dp_reset_i    = 1'b0;
    endtask

    task automatic dp_clear();
        dp_reset_i = 1'b1;
        adv();
    endtask

    task automatic set_x(input logic [15:0] v);
        signal_i    = v;
        rd_signal_i = 1'b1;
        adv();
    endtask

    task automatic set_coeff(input logic [15:0] v);
        rd_coeff_i = 1'b1;
        adv();
        coeff_i = v;
        adv();
    endtask

    task automatic do_mul(input logic [15:0] exp_prod);
        mul_valid_i = 1'b1;
        mul_q.push_back('{cyc + MUL_LAT, exp_prod, 1'b0});
        adv();
        repeat (MUL_LAT) adv();
    endtask

    task automatic do_add(input logic [15:0] exp_acc);
        add_valid_i = 1'b1;
        add_q.push_back('{cyc + 1, exp_acc, 1'b0});
        adv();
        adv();
    endtask

    task automatic do_load(input logic [15:0] exp_res, input logic exp_ovf);
        load_result_i = 1'b1;
        res_q.push_back('{cyc + 1, exp_res, exp_ovf});
        adv();
        adv();
    endtask

    logic [15:0] hc [3];
    logic [15:0] hp [3];
    logic [15:0] ha [3];

    initial begin
        rst_i = 1'b1;
        dp_reset_i = 0; rd_signal_i = 0; rd_coeff_i = 0; mul_valid_i = 0;
        add_valid_i = 0; load_result_i = 0; signal_i = '0; coeff_i = '0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        chk("rst_mul_done", {31'h0, mul_done_o}, 0);
        chk("rst_add_done", {31'h0, add_done_o}, 0);
        chk("rst_result", {16'h0, result_o}, 0);
        chk("rst_result_valid", {31'h0, result_valid_o}, 0);
        chk("rst_overflow", {31'h0, overflow_o}, 0);
        adv();

        // Horner Q4.12: x = 0.5, c = 1.0, 0.5, 0.25 -> 1.0, 1.0, 0.75
        hc = '{16'h1000, 16'h0800, 16'h0400};
        hp = '{16'h0000, 16'h0800, 16'h0800};
        ha = '{16'h1000, 16'h1000, 16'h0C00};
        dp_clear();
        set_x(16'h0800);
        for (int i = 0; i < 3; i++) begin
            set_coeff(hc[i]);
            do_mul(hp[i]);
            do_add(ha[i]);
        end
        do_load(16'h0C00, 1'b0);

        // Rounding: 1 LSB * 0.5 rounds up to 1; -1 LSB * 0.5 rounds up to 0
        dp_clear();
        set_x(16'h0800);
        set_coeff(16'h0001);
        do_add(16'h0001);
        do_mul(16'h0001);
        dp_clear();
        set_x(16'h0800);
        set_coeff(16'hFFFF);
        do_add(16'hFFFF);
        do_mul(16'h0000);

        // Multiply saturation then add saturation, sticky visible on load
        dp_clear();
        set_x(16'h7000);
        set_coeff(16'h7000);
        do_add(16'h7000);
        do_mul(16'h7FFF);
        set_coeff(16'h0100);
        do_add(16'h7FFF);
        do_load(16'h7FFF, 1'b1);

        // dp_reset one cycle after a multiply starts: no done, state cleared, result held
        mul_valid_i = 1'b1;
        adv();
        dp_clear();
        repeat (5) adv();
        chk("dpr_acc", {16'h0, $unsigned(dut.acc_q)}, 0);
        chk("dpr_sticky", {31'h0, dut.sat_sticky}, 0);
        chk("dpr_result_held", {16'h0, result_o}, 32'h7FFF);
        chk("dpr_overflow_held", {31'h0, overflow_o}, 1);
        do_load(16'h0000, 1'b0);

        // Handshake timing, second mul_valid ignored, add right after done
        dp_clear();
        set_x(16'h0800);
        set_coeff(16'h0400);
        do_add(16'h0400);
        mul_valid_i = 1'b1;
        mul_q.push_back('{cyc + MUL_LAT, 16'h0200, 1'b0});
        adv();
        mul_valid_i = 1'b1;
        adv();
        adv();
        adv();
        add_valid_i = 1'b1;
        add_q.push_back('{cyc + 1, 16'h0600, 1'b0});
        adv();
        adv();
        do_load(16'h0600, 1'b0);

        // load_result together with dp_reset captures the pre-clear accumulator
        dp_clear();
        set_coeff(16'h0123);
        do_add(16'h0123);
        load_result_i = 1'b1;
        dp_reset_i    = 1'b1;
        res_q.push_back('{cyc + 1, 16'h0123, 1'b0});
        adv();
        adv();
        chk("load_dpr_acc", {16'h0, $unsigned(dut.acc_q)}, 0);
        repeat (3) adv();

        // Asynchronous reset mid-multiply
        set_x(16'h0800);
        mul_valid_i = 1'b1;
        adv();
        #2 rst_i = 1'b1;
        #1;
        chk("arst_result", {16'h0, result_o}, 0);
        chk("arst_result_valid", {31'h0, result_valid_o}, 0);
        chk("arst_overflow", {31'h0, overflow_o}, 0);
        chk("arst_mul_done", {31'h0, mul_done_o}, 0);
        chk("arst_add_done", {31'h0, add_done_o}, 0);
        adv();
        rst_i = 1'b0;
        repeat (6) adv();

        chk("mul_q_drained", mul_q.size(), 0);
        chk("add_q_drained", add_q.size(), 0);
        chk("res_q_drained", res_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/horner_datapath.md
# horner_datapath

Fixed-point arithmetic datapath for the polynomial-approximation engine, sitting directly downstream of the sequencing controller. It executes one Horner step per controller iteration (acc = acc·x + c). It captures the input sample from the signal FIFO and coefficients from the synchronous coefficient ROM. It returns mul/add done handshakes and registers the final result on the controller's load strobe.

## Interface
- DATA_W, 16: signed width of sample, coefficient, accumulator and result.
- FRAC_W, 12: fractional bits, Q(DATA_W-FRAC_W).FRAC_W; 1 ≤ FRAC_W < DATA_W.
- MUL_LAT, 3: cycles from mul_valid_i to mul_done_o; ≥ 1.
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- dp_reset_i  in  1  synchronous per-evaluation clear from controller.
- rd_signal_i  in  1  FIFO read strobe; signal_i is valid in the same cycle (first-word-fall-through).
- signal_i  in  DATA_W  sample x from FIFO.
- rd_coeff_i  in  1  ROM read strobe; coeff_i is valid the following cycle.
- coeff_i  in  DATA_W  coefficient from ROM.
- mul_valid_i  in  1  start multiply acc·x.
- add_valid_i  in  1  start add product + coefficient.
- load_result_i  in  1  register acc to the output.
- mul_done_o  out  1  one-cycle pulse when the product is ready.
- add_done_o  out  1  one-cycle pulse when acc is updated.
- result_o  out  DATA_W  final polynomial value.
- result_valid_o  out  1  one-cycle pulse, the cycle after load_result_i.
- overflow_o  out  1  a saturation occurred during the evaluation now in result_o.

## Operation
- Registers: x_q, coeff_q, prod_q, acc_q, sat_sticky, mul pipeline valid shift (MUL_LAT bits), add_pend, result_q, ovf_q.
- rd_signal_i: x_q ← signal_i.
- rd_coeff_i: set rd_coeff_d for one cycle. In the next cycle, coeff_q ← coeff_i.
- Multiply: raw = acc_q·x_q, signed 2·DATA_W bits.
  - r = (raw + 2^(FRAC_W-1)) >>> FRAC_W (round half up, arithmetic shift).
  - Saturate r to [−2^(DATA_W−1), 2^(DATA_W−1)−1]. prod_q ← r.
  - Operands are sampled in the mul_valid_i cycle. The result is visible on prod_q when mul_done_o is high.
- Add: s = prod_q + coeff_q in DATA_W+1 bits, saturated to DATA_W. acc_q ← s on the cycle after add_valid_i, together with the add_done_o pulse.
- Any saturation in the multiply or the add sets sat_sticky.
- load_result_i: result_q ← acc_q and ovf_q ← sat_sticky. result_valid_o pulses the next cycle.
- dp_reset_i clears x_q, coeff_q, prod_q, acc_q, sat_sticky, the mul pipeline and add_pend. It does not clear result_q or ovf_q.
- Evaluation order is set by the controller: coefficients arrive highest-order first. The first step therefore computes acc = 0·x + c[n−1].

## Timing
- rst_i asserted: every register clears asynchronously. All outputs are 0 (mul_done_o, add_done_o, result_valid_o, overflow_o, result_o = 0) until the first clock edge after deassertion.
- Mul latency: mul_valid_i at cycle t → mul_done_o high at t+MUL_LAT, for exactly one cycle.
- Add latency: add_valid_i at t → acc_q updated and add_done_o high at t+1.
- mul_valid_i while a multiply is in flight: ignored, with no second done pulse.
- add_valid_i in the same cycle as, or before, mul_done_o: the add uses the current prod_q. This is a controller error and is not flagged.
- dp_reset_i has priority over every strobe in the same cycle. In-flight done pulses are killed.
- load_result_i together with dp_reset_i: result_q captures the pre-clear acc_q.
- rd_coeff_i on consecutive cycles: each strobe captures the ROM data that follows it.
- rst_i mid-evaluation: all state is lost. No done pulse is emitted after reset deassertion.

## Test plan
- Reset: assert rst_i asynchronously mid-multiply → all outputs 0 immediately. No mul_done_o after release.
- Horner, Q4.12, x = 0x0800, coefficients 0x1000, 0x0800, 0x0400, three controller-style iterations → acc 0x1000, 0x1000, then 0x0C00. On load, result_o = 0x0C00, result_valid_o pulses once, overflow_o = 0.
- Mul saturation: acc = 0x7000, x = 0x7000 → prod_q = 0x7FFF. Add 0x0100 → acc = 0x7FFF. On load, overflow_o = 1.
- Rounding: acc = 0x0001, x = 0x0800 → prod_q = 0x0001. acc = 0xFFFF, x = 0x0800 → prod_q = 0x0000.
- Handshake timing with MUL_LAT = 3: mul_valid_i at cycle 10 → mul_done_o only at cycle 13. A second mul_valid_i at cycle 11 is ignored. add_valid_i at 14 → add_done_o at 15.
- dp_reset_i at cycle 11, while the multiply from cycle 10 is in flight → no mul_done_o, acc_q = 0, sat_sticky cleared, result_o unchanged.
